serial_pattern_det: RTL
=======================

// Module: serial_pattern_det
// PURPOSE
//  Consumes the registered 1-bit stream produced by the d->q flip-flop stage and detects a
//  programmable PATTERN_W-bit pattern, MSB first. Pulses a match flag and keeps a saturating
//  match count. Sits directly downstream of the flip-flop stage.
// PARAMETERS
//  PATTERN_W  4        pattern length in bits (2..16)
//  PATTERN    4'b1101  pattern to detect; bit [PATTERN_W-1] is the oldest bit received
//  CNT_W      8        width of match counter
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          asynchronous, active-high reset
//  d          in   1          serial data bit (q of upstream flip-flop)
//  d_valid    in   1          d is sampled only when high
//  overlap    in   1          1: overlapping matches allowed; 0: window restarts after a match
//  clr        in   1          synchronous clear of window, FSM and counter
//  match      out  1          one-cycle pulse, registered
//  match_cnt  out  CNT_W      number of matches since reset/clr, saturating
//  cnt_sat    out  1          high while match_cnt == all-ones
//  window     out  PATTERN_W  current shift window, newest bit in [0]
// BEHAVIOUR
//  Reset (async, rst=1): window=0, fill=0, state=IDLE, match=0, match_cnt=0, cnt_sat=0.
//  All state updates occur on the rising edge of clk.
//  Shift: on d_valid=1, window <= {window[PATTERN_W-2:0], d}; on d_valid=0, window holds.
//  fill counter, 0..PATTERN_W, counts valid bits in the current window; saturates at PATTERN_W.
//  FSM:
//   IDLE -> FILL on the first d_valid.
//   FILL: stays until fill reaches PATTERN_W-1 and another valid bit arrives -> RUN.
//   RUN: each valid bit compares the next window ({window[PATTERN_W-2:0], d}) with PATTERN.
//        On equality, match=1 on the next cycle.
//        If overlap=1 on a match: stay in RUN.
//        If overlap=0 on a match: fill <= 0, state -> FILL. Window bits are kept, but the
//        next match needs PATTERN_W fresh bits.
//  Latency: match rises one cycle after the edge that samples the final pattern bit
//   (registered compare). match is never high for two cycles from one valid bit.
//  A match can be declared on the PATTERN_W-th valid bit after reset/clr. Bits of the
//   reset-value window never count.
//  Counter: on a match, match_cnt <= match_cnt+1 unless it is all-ones (holds; no wrap).
//   cnt_sat = &match_cnt. This is combinational from the register.
//  clr=1 (sync): acts as reset for all state. clr has priority over d_valid on the same edge,
//   and any bit presented with clr is dropped. rst has priority over clr.
//  d_valid=0 gaps of any length are transparent: the pattern may straddle a gap.
//  overlap is sampled per valid bit. Changing it mid-stream affects only the next match decision.
//  rst mid-pattern: the partial window is discarded; match drops immediately (async).
//  Widths: fill is $clog2(PATTERN_W+1) bits; the compare is exactly PATTERN_W bits.
// STRUCTURE
//  Shared package spd_pkg: state localparams IDLE=2'd0, FILL=2'd1, RUN=2'd2, and the default
//   pattern constant.
//  One sub-module, sat_counter (params W; ports clk, rst, clr, inc, cnt, sat), holds the
//   match counter. FSM, shift window and compare stay in this module.
//  The bench instantiates the flip-flop stage feeding d, so the two-stage chain is tested
//   end to end.
// TESTING
//  1. Reset: rst=1 at t=0 for 2 cycles, d random -> match=0, match_cnt=0, window=0.
//  2. Basic match: overlap=1, valid stream 1,1,0,1 -> match pulses 1 cycle after the 4th bit;
//     match_cnt=1.
//  3. Overlap: overlap=1, stream 1,1,0,1,1,0,1 -> 2 matches, match_cnt=2. With overlap=0 the
//     same stream -> 1 match.
//  4. Gaps: stream 1,1,<3 idle cycles>,0,1 -> match=1 once. Leading 1,0,1 after reset -> no match.
//  5. Saturation: CNT_W=2, 5 non-overlapping matches -> match_cnt sticks at 3, cnt_sat=1,
//     match still pulses.
//  6. clr/rst mid-pattern: 1,1,0 then clr with d=1 -> no match. 1,1,0 then async rst between
//     edges -> outputs zero at once; the next 1,1,0,1 matches.

Source files
------------

// File: rtl/spd_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding and
// the default pattern.
package spd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } spd_state_t;

    localparam int              DEFAULT_PATTERN_W = 4;
    localparam logic [3:0]      DEFAULT_PATTERN   = 4'b1101;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !(&cnt_q)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = &cnt_q;

endmodule

// File: rtl/serial_pattern_det.sv
// Serial pattern detector: shifts valid bits into a window, compares the next
// window against PATTERN (MSB oldest) and pulses a registered match flag.
module serial_pattern_det
    import spd_pkg::*;
#(
    parameter int                   PATTERN_W = DEFAULT_PATTERN_W,
    parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(DEFAULT_PATTERN),
    parameter int                   CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 d,
    input  logic                 d_valid,
    input  logic                 overlap,
    input  logic                 clr,
    output logic                 match,
    output logic [CNT_W-1:0]     match_cnt,
    output logic                 cnt_sat,
    output logic [PATTERN_W-1:0] window
);

    localparam int                FILL_W    = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PATTERN_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

    spd_state_t           state_q;
    spd_state_t           state_d;
    logic [FILL_W-1:0]    fill_q;
    logic [FILL_W-1:0]    fill_d;
    logic [PATTERN_W-1:0] window_q;
    logic [PATTERN_W-1:0] window_d;
    logic [PATTERN_W-1:0] window_shift;
    logic                 match_q;
    logic                 match_d;
    logic                 hit;

    // Compare the window as it will look after this bit, so the result can be registered.
    assign window_shift = {window_q[PATTERN_W-2:0], d};
    assign hit          = (window_shift == PATTERN);

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        window_d = window_q;
        match_d  = 1'b0;
        if (clr) begin
            state_d  = IDLE;
            fill_d   = '0;
            window_d = '0;
        end else if (d_valid) begin
            window_d = window_shift;
            case (state_q)
                IDLE: begin
                    fill_d  = FILL_W'(1);
                    state_d = FILL;
                end
                FILL: begin
                    if (fill_q == FILL_LAST) begin
                        fill_d  = FILL_FULL;
                        state_d = RUN;
                        if (hit) begin
                            match_d = 1'b1;
                            if (!overlap) begin
                                fill_d  = '0;
                                state_d = FILL;
                            end
                        end
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                RUN: begin
                    if (hit) begin
                        match_d = 1'b1;
                        // Without overlap the kept window bits are stale; demand a full refill.
                        if (!overlap) begin
                            fill_d  = '0;
                            state_d = FILL;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    fill_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            fill_q   <= '0;
            window_q <= '0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            window_q <= window_d;
            match_q  <= match_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (match_d),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

    assign match  = match_q;
    assign window = window_q;

endmodule
